// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback arbiter merging the ALU result stream (priority) with
//            FIFO-buffered memory returns onto the single GPR write port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NUM_THREADS  = 4,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [3:0]                    alu_rD,
    input  logic [NUM_THREADS-1:0]        alu_mask,
    input  logic [NUM_THREADS*DATA_W-1:0] alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [3:0]                    mem_rD,
    input  logic [NUM_THREADS-1:0]        mem_mask,
    input  logic [NUM_THREADS*DATA_W-1:0] mem_data,
    output logic                          wb_rf_we,
    output logic [3:0]                    wb_rD_addr,
    output logic [NUM_THREADS-1:0]        wb_active_mask,
    output logic [NUM_THREADS*DATA_W-1:0] wb_data,
    output logic                          ex_hold,
    output logic                          proto_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);
    localparam int c_BW = NUM_THREADS * DATA_W;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(FIFO_DEPTH);

    logic [3:0]             r_fifo_rd   [FIFO_DEPTH];
    logic [NUM_THREADS-1:0] r_fifo_mask [FIFO_DEPTH];
    logic [c_BW-1:0]        r_fifo_data [FIFO_DEPTH];

    logic [c_AW-1:0]        r_wptr;
    logic [c_AW-1:0]        r_rptr;
    logic [c_CW-1:0]        r_count;
    logic [c_SW-1:0]        r_starve;
    logic                   r_perr;
    logic                   r_wb_we;
    logic [3:0]             r_wb_rd;
    logic [NUM_THREADS-1:0] r_wb_mask;
    logic [c_BW-1:0]        r_wb_data;

    logic                   w_ready;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_sel;
    logic                   w_hold;
    logic [3:0]             w_sel_rd;
    logic [NUM_THREADS-1:0] w_sel_mask;
    logic [c_BW-1:0]        w_sel_data;

    always_comb begin
        w_ready  = (r_count < c_DEPTH);
        w_empty  = (r_count == '0);
        w_hold   = (r_starve == c_STARVE_MAX) && !w_empty;
        w_pop    = !alu_valid && !w_empty;
        // An empty FIFO lets an idle-cycle return go straight to writeback.
        w_bypass = !alu_valid && w_empty && mem_valid && w_ready;
        w_push   = mem_valid && w_ready && !w_bypass;
        w_sel    = alu_valid || w_pop || w_bypass;

        w_sel_rd   = mem_rD;
        w_sel_mask = mem_mask;
        w_sel_data = mem_data;
        if (alu_valid) begin
            w_sel_rd   = alu_rD;
            w_sel_mask = alu_mask;
            w_sel_data = alu_data;
        end else if (w_pop) begin
            w_sel_rd   = r_fifo_rd[r_rptr];
            w_sel_mask = r_fifo_mask[r_rptr];
            w_sel_data = r_fifo_data[r_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mem_rD;
            r_fifo_mask[r_wptr] <= mem_mask;
            r_fifo_data[r_wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_perr    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_mask <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end

            // Counts consecutive cycles a buffered head loses to the ALU.
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (alu_valid && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + c_SW'(1);
            end

            if (alu_valid && w_hold) begin
                r_perr <= 1'b1;
            end

            r_wb_we <= w_sel;
            if (w_sel) begin
                r_wb_rd   <= w_sel_rd;
                r_wb_mask <= w_sel_mask;
                r_wb_data <= w_sel_data;
            end
        end
    end

    assign mem_ready      = w_ready;
    assign ex_hold        = w_hold;
    assign proto_err      = r_perr;
    assign wb_rf_we       = r_wb_we;
    assign wb_rD_addr     = r_wb_rd;
    assign wb_active_mask = r_wb_mask;
    assign wb_data        = r_wb_data;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter that merges the fixed-latency ALU result stream and the variable-latency memory load-return stream onto the single GPR write port.
- Produces the WB sideband (rD, rf_we, active mask) that the scoreboard uses to clear pending bits.
- Memory returns are buffered in a small FIFO. The ALU stream has priority.
- A starvation counter requests a one-cycle EX hold so buffered loads always retire.

Parameters:
- NUM_THREADS, 4, lanes per warp; sets mask width and data bus width.
- DATA_W, 16, per-thread register data width.
- FIFO_DEPTH, 4, memory-return buffer entries (power of two, >=2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose arbitration before ex_hold asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result is present this cycle. Cannot be back-pressured.
- alu_rD  in  4  ALU destination register.
- alu_mask  in  NUM_THREADS  active mask snapshot from issue.
- alu_data  in  NUM_THREADS*DATA_W  per-thread results; thread t occupies bits [t*DATA_W +: DATA_W].
- mem_valid  in  1  load return offered.
- mem_ready  out  1  FIFO can accept a return.
- mem_rD  in  4  load destination register.
- mem_mask  in  NUM_THREADS  load active mask.
- mem_data  in  NUM_THREADS*DATA_W  load data.
- wb_rf_we  out  1  GPR write commit.
- wb_rD_addr  out  4  register written.
- wb_active_mask  out  NUM_THREADS  per-thread write enables.
- wb_data  out  NUM_THREADS*DATA_W  write data.
- ex_hold  out  1  request upstream to suppress alu_valid next cycle.
- proto_err  out  1  sticky: alu_valid seen while ex_hold was high.

Behaviour:
- Reset values: all wb_* = 0, ex_hold = 0, proto_err = 0. FIFO count = 0, read/write pointers = 0, starve counter = 0, so mem_ready = 1 after reset.
- Reset asserted mid-operation discards all FIFO contents and any pending write. The cycle after rst deasserts, wb_rf_we = 0.
- Push: the FIFO accepts a return when mem_valid & mem_ready.
- mem_ready = (count < FIFO_DEPTH). It is derived from registered count only. A same-cycle pop does not free a slot early.
- Arbitration, evaluated each cycle:
  - If alu_valid: the ALU is selected.
  - Else if the FIFO is non-empty: the head is popped and selected.
  - Else if mem_valid & mem_ready: the incoming return bypasses the FIFO and is selected. No push occurs.
  - Else: nothing is selected.
- Output register: the selected entry is latched into the wb_* registers, so latency from input to wb_* is exactly 1 cycle.
  - wb_rf_we = 1 iff something was selected.
  - When nothing is selected, wb_rf_we = 0 and wb_rD_addr/wb_active_mask/wb_data hold their previous values.
  - A selected entry with mask 0 is still committed with wb_rf_we = 1 and mask 0.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Order is strict FIFO.
- Starve counter:
  - Increments when the FIFO is non-empty and alu_valid is high.
  - Clears to 0 on any pop, and when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- ex_hold = (starve_cnt == STARVE_LIMIT) & (count != 0). It is combinational from registered state.
- Upstream contract: alu_valid = 0 in any cycle where ex_hold = 1.
  - That cycle the head pops and the counter clears, so ex_hold is high for exactly 1 cycle.
  - If alu_valid = 1 while ex_hold = 1: the ALU still wins, proto_err sets and stays set until rst, and the counter stays saturated.
- Data integrity: wb_data lanes map 1:1 to input lanes. No lane reordering or masking of data is done; masking is left to the RF write enables.

Test Plan:
- Reset, then a single ALU result (alu_rD=5, mask=4'b1011, data=0x1111_2222_3333_4444) -> the next cycle shows wb_rf_we=1, rD=5, mask=1011, data identical; mem_ready=1 throughout.
- mem_valid only, empty FIFO, rD=7 -> bypass: wb_rf_we=1, rD=7 one cycle later; count stays 0.
- Hold alu_valid=1 for 8 cycles while pushing 5 returns (rD=1..5) -> 4 accepted, mem_ready=0 after the 4th; ex_hold asserts on the 4th cycle after the first buffered loss; proto_err=1 because the bench keeps alu_valid high.
- Same as the previous case but the bench drops alu_valid whenever ex_hold=1 -> ex_hold lasts exactly one cycle; loads retire in order rD=1,2,3,4 interleaved; proto_err stays 0.
- Fill FIFO to 4, then idle the ALU while pushing continuously -> loads retire one per cycle in order; simultaneous push/pop keeps count constant; pointers wrap past index 3 with no loss or duplication.
- Assert rst with 3 entries buffered and wb_rf_we=1 -> next cycle all outputs are 0, mem_ready=1, and no stale entry is ever written back.
